// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Arbitrates between the instruction cache (read-only line fills) and the data
// cache (line fills and write-backs) for one shared dual-port memory. Only one
// transaction is in flight at a time. Read data is returned MEM_LATENCY cycles
// after the read is issued.
//
// Sequence per transaction: IDLE (latch the winner) -> ISSUE (grant + memory
// enable) -> WAIT (reads only, MEM_LATENCY cycles) -> RESP (valid pulse) -> IDLE.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   ic_req/ic_addr               i-cache read request (level) and address
//   ic_gnt/ic_valid/ic_data      i-cache grant pulse, response pulse, read data
//   dc_req/dc_we/dc_addr/dc_wdata  d-cache request (level), write flag, address,
//                                write data
//   dc_gnt/dc_valid/dc_data      d-cache grant pulse, response pulse, read data
//   mem_rdaddress/mem_rden       memory read port
//   mem_wraddress/mem_wren/mem_data  memory write port
//   mem_q                        memory read data
//   busy                         high whenever the FSM is not in IDLE
//
// Build option:
//   MEM_PORT_ARB_RR_EN  defined   -> round-robin arbitration on simultaneous
//                                    requests (pointer resets to i-cache, so the
//                                    d-cache wins the first tie)
//                       undefined -> fixed priority, d-cache over i-cache
//
// All outputs are registered; their next values are derived from the next
// FSM state so that they line up with the state they belong to.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_WIDTH   = 64,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_gnt,
  output logic                  ic_valid,
  output logic [MEM_WIDTH-1:0]  ic_data,
  input  logic                  dc_req,
  input  logic                  dc_we,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [MEM_WIDTH-1:0]  dc_wdata,
  output logic                  dc_gnt,
  output logic                  dc_valid,
  output logic [MEM_WIDTH-1:0]  dc_data,
  output logic [ADDR_WIDTH-1:0] mem_rdaddress,
  output logic                  mem_rden,
  output logic [ADDR_WIDTH-1:0] mem_wraddress,
  output logic                  mem_wren,
  output logic [MEM_WIDTH-1:0]  mem_data,
  input  logic [MEM_WIDTH-1:0]  mem_q,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Last WAIT cycle index; the counter runs 0 .. MEM_LATENCY-1.
  localparam logic [2:0] CNT_LAST = 3'(MEM_LATENCY - 1);

  state_t                state_q, state_d;
  logic                  win_dc_q, win_dc_d;   // 1 = d-cache owns the transaction
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [MEM_WIDTH-1:0]  wdata_q, wdata_d;
  logic [2:0]            cnt_q, cnt_d;

  logic                  ic_gnt_q, ic_gnt_d;
  logic                  ic_valid_q, ic_valid_d;
  logic [MEM_WIDTH-1:0]  ic_data_q, ic_data_d;
  logic                  dc_gnt_q, dc_gnt_d;
  logic                  dc_valid_q, dc_valid_d;
  logic [MEM_WIDTH-1:0]  dc_data_q, dc_data_d;
  logic [ADDR_WIDTH-1:0] mem_rdaddress_q, mem_rdaddress_d;
  logic                  mem_rden_q, mem_rden_d;
  logic [ADDR_WIDTH-1:0] mem_wraddress_q, mem_wraddress_d;
  logic                  mem_wren_q, mem_wren_d;
  logic [MEM_WIDTH-1:0]  mem_data_q, mem_data_d;
  logic                  busy_q, busy_d;

  logic                  pick_dc;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef MEM_PORT_ARB_RR_EN
  // Pointer holds the last granted requester (1 = d-cache). On a tie the
  // other requester wins; reset value i-cache lets the d-cache win first.
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    if (ic_req && dc_req) begin
      pick_dc = ~rr_ptr_q;
    end else begin
      pick_dc = dc_req;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == ISSUE) begin
      rr_ptr_d = win_dc_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Fixed priority: the d-cache always wins; the i-cache can starve.
  always_comb begin
    pick_dc = dc_req;
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    win_dc_d        = win_dc_q;
    addr_d          = addr_q;
    we_d            = we_q;
    wdata_d         = wdata_q;
    cnt_d           = cnt_q;
    ic_data_d       = ic_data_q;
    dc_data_d       = dc_data_q;
    // Pulses and memory controls default to inactive; address/data outputs
    // are forced to zero whenever their enable is low.
    ic_gnt_d        = 1'b0;
    ic_valid_d      = 1'b0;
    dc_gnt_d        = 1'b0;
    dc_valid_d      = 1'b0;
    mem_rdaddress_d = '0;
    mem_rden_d      = 1'b0;
    mem_wraddress_d = '0;
    mem_wren_d      = 1'b0;
    mem_data_d      = '0;

    case (state_q)
      IDLE: begin
        if (ic_req || dc_req) begin
          win_dc_d = pick_dc;
          addr_d   = pick_dc ? dc_addr : ic_addr;
          // Only the d-cache can write; an i-cache transaction is always a read.
          we_d     = pick_dc & dc_we;
          wdata_d  = pick_dc ? dc_wdata : '0;
          state_d  = ISSUE;
          // Outputs that belong to the upcoming ISSUE cycle.
          ic_gnt_d = ~pick_dc;
          dc_gnt_d = pick_dc;
          if (pick_dc && dc_we) begin
            mem_wren_d      = 1'b1;
            mem_wraddress_d = dc_addr;
            mem_data_d      = dc_wdata;
          end else begin
            mem_rden_d      = 1'b1;
            mem_rdaddress_d = pick_dc ? dc_addr : ic_addr;
          end
        end
      end

      ISSUE: begin
        cnt_d = 3'd0;
        if (we_q) begin
          // Write completes immediately; response carries no data.
          state_d    = RESP;
          dc_valid_d = 1'b1;
          dc_data_d  = '0;
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 3'd0;
          state_d = RESP;
          // mem_q is valid in this final WAIT cycle; capture it for RESP.
          if (win_dc_q) begin
            dc_valid_d = 1'b1;
            dc_data_d  = mem_q;
          end else begin
            ic_valid_d = 1'b1;
            ic_data_d  = mem_q;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      win_dc_q        <= 1'b0;
      addr_q          <= '0;
      we_q            <= 1'b0;
      wdata_q         <= '0;
      cnt_q           <= 3'd0;
      ic_gnt_q        <= 1'b0;
      ic_valid_q      <= 1'b0;
      ic_data_q       <= '0;
      dc_gnt_q        <= 1'b0;
      dc_valid_q      <= 1'b0;
      dc_data_q       <= '0;
      mem_rdaddress_q <= '0;
      mem_rden_q      <= 1'b0;
      mem_wraddress_q <= '0;
      mem_wren_q      <= 1'b0;
      mem_data_q      <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      win_dc_q        <= win_dc_d;
      addr_q          <= addr_d;
      we_q            <= we_d;
      wdata_q         <= wdata_d;
      cnt_q           <= cnt_d;
      ic_gnt_q        <= ic_gnt_d;
      ic_valid_q      <= ic_valid_d;
      ic_data_q       <= ic_data_d;
      dc_gnt_q        <= dc_gnt_d;
      dc_valid_q      <= dc_valid_d;
      dc_data_q       <= dc_data_d;
      mem_rdaddress_q <= mem_rdaddress_d;
      mem_rden_q      <= mem_rden_d;
      mem_wraddress_q <= mem_wraddress_d;
      mem_wren_q      <= mem_wren_d;
      mem_data_q      <= mem_data_d;
      busy_q          <= busy_d;
    end
  end

  assign ic_gnt        = ic_gnt_q;
  assign ic_valid      = ic_valid_q;
  assign ic_data       = ic_data_q;
  assign dc_gnt        = dc_gnt_q;
  assign dc_valid      = dc_valid_q;
  assign dc_data       = dc_data_q;
  assign mem_rdaddress = mem_rdaddress_q;
  assign mem_rden      = mem_rden_q;
  assign mem_wraddress = mem_wraddress_q;
  assign mem_wren      = mem_wren_q;
  assign mem_data      = mem_data_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Instance dut uses MEM_LATENCY=1, instance
// dut3 uses MEM_LATENCY=3 and only receives i-cache reads. A small memory model
// (16 words, word index = address[6:3]) serves both instances; dut3 sees a
// three-stage read pipeline. Inputs are driven and outputs sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int MW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic          ic_gnt, ic_valid;
  logic [MW-1:0] ic_data;
  logic          dc_req, dc_we;
  logic [AW-1:0] dc_addr;
  logic [MW-1:0] dc_wdata;
  logic          dc_gnt, dc_valid;
  logic [MW-1:0] dc_data;
  logic [AW-1:0] mem_rdaddress, mem_wraddress;
  logic          mem_rden, mem_wren;
  logic [MW-1:0] mem_data, mem_q;
  logic          busy;

  logic          ic_req3;
  logic [AW-1:0] ic_addr3;
  logic          ic_gnt3, ic_valid3;
  logic [MW-1:0] ic_data3;
  logic          dc_gnt3, dc_valid3;
  logic [MW-1:0] dc_data3;
  logic [AW-1:0] mem_rdaddress3, mem_wraddress3;
  logic          mem_rden3, mem_wren3;
  logic [MW-1:0] mem_data3, mem_q3;
  logic          busy3;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .MEM_WIDTH(MW), .MEM_LATENCY(1)) dut (
    .clock(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_valid(ic_valid), .ic_data(ic_data),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_gnt(dc_gnt), .dc_valid(dc_valid), .dc_data(dc_data),
    .mem_rdaddress(mem_rdaddress), .mem_rden(mem_rden), .mem_wraddress(mem_wraddress),
    .mem_wren(mem_wren), .mem_data(mem_data), .mem_q(mem_q), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_WIDTH(AW), .MEM_WIDTH(MW), .MEM_LATENCY(3)) dut3 (
    .clock(clk), .reset(reset),
    .ic_req(ic_req3), .ic_addr(ic_addr3), .ic_gnt(ic_gnt3), .ic_valid(ic_valid3), .ic_data(ic_data3),
    .dc_req(1'b0), .dc_we(1'b0), .dc_addr({AW{1'b0}}), .dc_wdata({MW{1'b0}}),
    .dc_gnt(dc_gnt3), .dc_valid(dc_valid3), .dc_data(dc_data3),
    .mem_rdaddress(mem_rdaddress3), .mem_rden(mem_rden3), .mem_wraddress(mem_wraddress3),
    .mem_wren(mem_wren3), .mem_data(mem_data3), .mem_q(mem_q3), .busy(busy3)
  );

  // Memory model: preload port, write port from dut, read ports for both.
  logic [MW-1:0] mem [0:15];
  logic          pl_en;
  logic [3:0]    pl_idx;
  logic [MW-1:0] pl_data;
  logic [MW-1:0] p3 [0:2];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (mem_wren) mem[mem_wraddress[6:3]] <= mem_data;
    if (mem_rden) mem_q <= mem[mem_rdaddress[6:3]];
    if (mem_rden3) p3[0] <= mem[mem_rdaddress3[6:3]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_q3 = p3[2];

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  localparam logic [MW-1:0] W1 = 64'h0123456789ABCDEF;
  localparam logic [MW-1:0] W2 = 64'h2222222222222222;
  localparam logic [MW-1:0] W3 = 64'h3333333333333333;
  localparam logic [MW-1:0] WB = 64'hBADDBEEF00000000;

`ifdef MEM_PORT_ARB_RR_EN
  localparam logic [3:0] TIE_ORDER = 4'b1011;   // d, i, d, d
`else
  localparam logic [3:0] TIE_ORDER = 4'b1110;   // d, d, d, i
`endif

  initial begin
    logic [3:0] gseq;
    int         ng, ndc, last_g;

    reset = 1'b1;
    ic_req = 1'b0; ic_addr = '0;
    dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
    ic_req3 = 1'b0; ic_addr3 = '0;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    repeat (2) @(negedge clk);

    // Preload while reset is held.
    pl_en = 1'b1; pl_idx = 4'd1; pl_data = W1; @(negedge clk);
    pl_idx = 4'd2; pl_data = W2; @(negedge clk);
    pl_idx = 4'd3; pl_data = W3; @(negedge clk);
    pl_en = 1'b0;

    // ---- Reset state ----
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pulses", 64'({ic_gnt, dc_gnt, ic_valid, dc_valid}), 64'd0);
    chk("rst_ic_data", ic_data, 64'd0);
    chk("rst_dc_data", dc_data, 64'd0);
    chk("rst_mem_en", 64'({mem_rden, mem_wren}), 64'd0);
    chk("rst_mem_rdaddr", 64'(mem_rdaddress), 64'd0);
    chk("rst_mem_wraddr", 64'(mem_wraddress), 64'd0);
    chk("rst_mem_data", mem_data, 64'd0);
    chk("rst_dut3_ctl", 64'({busy3, ic_gnt3, ic_valid3, dc_gnt3, dc_valid3, mem_rden3, mem_wren3}), 64'd0);
    chk("rst_dut3_data", ic_data3 | dc_data3 | mem_data3 | 64'(mem_wraddress3), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // ---- i-cache read of 0x8 ----
    ic_req = 1'b1; ic_addr = 32'h8;              // cycle 0
    @(negedge clk);                              // cycle 1
    chk("rd_ic_gnt", 64'({ic_gnt, dc_gnt}), 64'b10);
    chk("rd_mem_rden", 64'(mem_rden), 64'd1);
    chk("rd_mem_rdaddr", 64'(mem_rdaddress), 64'h8);
    chk("rd_busy_c1", 64'(busy), 64'd1);
    chk("rd_mem_wren", 64'(mem_wren), 64'd0);
    @(negedge clk);                              // cycle 2
    chk("rd_valid_c2", 64'(ic_valid), 64'd0);
    chk("rd_rden_off", 64'({mem_rden, mem_rdaddress}), 64'd0);
    @(negedge clk);                              // cycle 3
    chk("rd_valid_c3", 64'(ic_valid), 64'd1);
    chk("rd_ic_data", ic_data, W1);
    ic_req = 1'b0;
    @(negedge clk);                              // cycle 4
    chk("rd_valid_c4", 64'(ic_valid), 64'd0);
    chk("rd_busy_c4", 64'(busy), 64'd0);
    chk("rd_data_hold", ic_data, W1);

    // ---- d-cache write-back of 0x8 ----
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h8; dc_wdata = WB;
    @(negedge clk);                              // cycle 1
    chk("wr_dc_gnt", 64'({ic_gnt, dc_gnt}), 64'b01);
    chk("wr_mem_wren", 64'({mem_wren, mem_rden}), 64'b10);
    chk("wr_mem_wraddr", 64'(mem_wraddress), 64'h8);
    chk("wr_mem_data", mem_data, WB);
    @(negedge clk);                              // cycle 2
    chk("wr_dc_valid", 64'(dc_valid), 64'd1);
    chk("wr_dc_data", dc_data, 64'd0);
    chk("wr_wren_off", 64'({mem_wren, mem_wraddress}) | mem_data, 64'd0);
    dc_req = 1'b0; dc_we = 1'b0;
    @(negedge clk);
    chk("wr_busy_done", 64'({busy, dc_valid}), 64'd0);

    // Read back the written word.
    ic_req = 1'b1; ic_addr = 32'h8;
    repeat (3) @(negedge clk);
    chk("rb_valid", 64'(ic_valid), 64'd1);
    chk("rb_data", ic_data, WB);
    ic_req = 1'b0;
    @(negedge clk);

    // ---- Simultaneous requests: d-cache 3 reads of 0x10, i-cache 1 read of 0x18 ----
    ic_req = 1'b1; ic_addr = 32'h18;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h10;
    gseq = 4'd0; ng = 0; ndc = 0; last_g = -1;
    for (int c = 0; c < 40 && (ic_req || dc_req); c++) begin
      @(negedge clk);
      if (ic_gnt || dc_gnt) begin
        chk("tie_gnt_onehot", 64'(ic_gnt & dc_gnt), 64'd0);
        if (last_g >= 0) chk("tie_grant_gap", 64'(c - last_g), 64'd4);
        gseq = {gseq[2:0], dc_gnt};
        last_g = c;
        ng++;
      end
      if (dc_valid) begin
        chk("tie_dc_data", dc_data, W2);
        ndc++;
        if (ndc == 3) dc_req = 1'b0;
      end
      if (ic_valid) begin
        chk("tie_ic_data", ic_data, W3);
        ic_req = 1'b0;
      end
    end
    chk("tie_all_done", 64'({ic_req, dc_req}), 64'd0);
    chk("tie_grant_count", 64'(ng), 64'd4);
    chk("tie_grant_order", 64'(gseq), 64'(TIE_ORDER));
    @(negedge clk);

    // ---- Reset during WAIT of a d-cache read ----
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h10;
    @(negedge clk);                              // cycle 1
    chk("rw_dc_gnt", 64'(dc_gnt), 64'd1);
    @(negedge clk);                              // cycle 2 (WAIT)
    reset = 1'b1;
    @(negedge clk);
    chk("rw_no_valid", 64'({dc_valid, ic_valid}), 64'd0);
    chk("rw_busy", 64'(busy), 64'd0);
    chk("rw_outs_zero", 64'({ic_gnt, dc_gnt, mem_rden, mem_wren, mem_rdaddress}), 64'd0);
    chk("rw_data_zero", dc_data | ic_data | mem_data, 64'd0);
    reset = 1'b0;                                // request still held: cycle 0
    @(negedge clk);
    chk("rw_regrant", 64'(dc_gnt), 64'd1);
    @(negedge clk);
    chk("rw_valid_c2", 64'(dc_valid), 64'd0);
    @(negedge clk);
    chk("rw_valid_c3", 64'(dc_valid), 64'd1);
    chk("rw_dc_data", dc_data, W2);
    dc_req = 1'b0;
    @(negedge clk);

    // ---- Address change after the IDLE latch ----
    ic_req = 1'b1; ic_addr = 32'h18;
    @(negedge clk);                              // cycle 1
    chk("ac_rdaddr", 64'(mem_rdaddress), 64'h18);
    ic_addr = 32'h10;
    @(negedge clk);                              // cycle 2 (WAIT)
    ic_addr = 32'h8;
    @(negedge clk);                              // cycle 3
    chk("ac_valid", 64'(ic_valid), 64'd1);
    chk("ac_data", ic_data, W3);
    ic_req = 1'b0;
    @(negedge clk);

    // ---- MEM_LATENCY = 3 instance ----
    ic_req3 = 1'b1; ic_addr3 = 32'h8;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      chk($sformatf("l3_busy_c%0d", cyc), 64'(busy3), 64'd1);
      chk($sformatf("l3_valid_c%0d", cyc), 64'(ic_valid3), 64'(cyc == 5));
      if (cyc == 1) chk("l3_gnt", 64'({ic_gnt3, mem_rden3}), 64'b11);
      if (cyc == 5) begin
        chk("l3_data", ic_data3, WB);
        ic_req3 = 1'b0;
      end
    end
    @(negedge clk);
    chk("l3_busy_done", 64'(busy3), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer sharing the single dual-port `mem` block between the instruction cache (read-only line fills) and the `data_cache` (line fills and write-backs). It serialises transactions and drives the memory's read and write ports. It returns fill data after the memory's synchronous read latency. One transaction is in flight at a time.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width on both requester and memory sides
- `MEM_WIDTH`, 64, memory word width
- `MEM_LATENCY`, 1, cycles from `mem_rden` issue edge until `mem_q` is valid; legal range 1–7

Ports:
- `clock`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `ic_req`  in  1  i-cache read request; level, held until `ic_valid`
- `ic_addr`  in  ADDR_WIDTH  i-cache read address; stable while `ic_req`
- `ic_gnt`  out  1  one-cycle pulse: i-cache request issued to memory
- `ic_valid`  out  1  one-cycle pulse: `ic_data` valid
- `ic_data`  out  MEM_WIDTH  read data
- `dc_req`  in  1  d-cache request; level, held until `dc_valid`
- `dc_we`  in  1  1 = write-back, 0 = fill read
- `dc_addr`  in  ADDR_WIDTH  d-cache address
- `dc_wdata`  in  MEM_WIDTH  write data
- `dc_gnt`  out  1  one-cycle pulse: d-cache request issued
- `dc_valid`  out  1  one-cycle pulse: read data valid or write complete
- `dc_data`  out  MEM_WIDTH  read data
- `mem_rdaddress`  out  ADDR_WIDTH  to `mem.rdaddress`
- `mem_rden`  out  1  to `mem.rden`
- `mem_wraddress`  out  ADDR_WIDTH  to `mem.wraddress`
- `mem_wren`  out  1  to `mem.wren`
- `mem_data`  out  MEM_WIDTH  to `mem.data`
- `mem_q`  in  MEM_WIDTH  from `mem.q`
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `*_req` is high, pick a winner and latch its id, address, `we` and wdata. Next state is ISSUE; otherwise stay in IDLE.
- ISSUE (1 cycle): pulse the winner's `*_gnt`.
  - For a read: `mem_rden`=1, `mem_rdaddress`=latched address.
  - For a write: `mem_wren`=1, `mem_wraddress`/`mem_data`=latched values.
  - Next state: reads go to WAIT, writes go to RESP.
- WAIT: a 3-bit counter runs MEM_LATENCY cycles. `mem_q` is captured into the response register on the final WAIT cycle. Next state is RESP.
- RESP (1 cycle): pulse the winner's `*_valid`. Drive `*_data` from the response register; `dc_data` is 0 for writes. Next state is IDLE.
- Requesters must drop `*_req` on the edge where they sample `*_valid`=1. IDLE therefore never re-grants a completed request.
- Arbitration without the macro: fixed priority, d-cache wins over i-cache.
- `ic_addr`/`dc_addr` changes after the IDLE latch are ignored.
- The `*_data` ports hold the last captured value between responses.
- Memory address/data outputs are 0 whenever their enable is 0.

## Timing
- Reset values: all outputs 0, FSM=IDLE, counter=0, latched id/address/data=0, RR pointer=i-cache.
- Read latency, counting the cycle `req` is first seen in IDLE as cycle 0:
  - ISSUE and `gnt` in cycle 1.
  - WAIT in cycles 2..1+MEM_LATENCY.
  - `valid` in cycle 2+MEM_LATENCY (cycle 3 for the default).
- Write latency: `gnt`/`mem_wren` in cycle 1, `dc_valid` in cycle 2.
- Throughput: back-to-back requests see one IDLE cycle between RESP and the next ISSUE.
- Simultaneous `ic_req` and `dc_req` in IDLE: resolved by the arbitration rule; the loser waits with its request held.
- `reset` asserted in any state:
  - Next cycle is IDLE with all outputs 0.
  - The in-flight transaction is dropped; no `valid` is issued for it.
  - A `mem_wren` pulse that already occurred is not undone.

## Configuration
- `MEM_PORT_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer records the last granted requester and updates in ISSUE.
  - On a tie, the requester not last granted wins.
  - The pointer resets to i-cache, so the d-cache wins the first tie.
- Not defined: fixed d-cache priority and no pointer register. An i-cache request can starve under a continuous d-cache load.

## Test plan
- Reset, then `ic_req`=1, `ic_addr`=0x8, `mem` word 1 preloaded with 0x0123456789ABCDEF -> `mem_rden` in cycle 1 with address 0x8; `ic_valid` in cycle 3 with `ic_data`=0x0123456789ABCDEF.
- `dc_req`=1, `dc_we`=1, `dc_addr`=0x8, `dc_wdata`=0xBADDBEEF00000000 -> `mem_wren` in cycle 1 with matching address/data; `dc_valid` in cycle 2. A subsequent i-cache read of 0x8 returns 0xBADDBEEF00000000.
- Both requests held in the same cycle, three rounds of read-backs:
  - Without the macro: d-cache granted all three rounds before the i-cache.
  - With `MEM_PORT_ARB_RR_EN`: grants alternate d, i, d.
- `reset` pulsed during WAIT of a d-cache read -> no `dc_valid`, all outputs 0 in the next cycle, `busy`=0. A new request afterwards completes normally.
- MEM_LATENCY=3 -> `ic_valid` in cycle 5; `busy` high in cycles 1–5.
- `ic_addr` changed during WAIT -> the returned data matches the address latched in IDLE.
